// File: rtl/shift_sequencer.sv
// Serial shifter: applies one bit-position of SRL/SLL/SRA/ROR per clock to an
// accumulator, under a start/busy/done handshake with back-to-back acceptance.
module shift_sequencer #(
  parameter int unsigned N   = 8,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   din,
  input  logic [SHW-1:0] shamt,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           done_q, done_d;
  logic [N-1:0]   step_val;

  always_comb begin
    step_val = acc_q;
    unique case (op_q)
      2'b00: step_val = {1'b0, acc_q[N-1:1]};
      2'b01: step_val = {acc_q[N-2:0], 1'b0};
      2'b10: step_val = {acc_q[N-1], acc_q[N-1:1]};
      2'b11: step_val = {acc_q[0], acc_q[N-1:1]};
      default: step_val = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d   = din;
          cnt_d   = shamt;
          op_d    = op;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // The cnt == 0 cycle only publishes the result; no shift happens here.
        if (cnt_q != '0) begin
          acc_d = step_val;
          cnt_d = cnt_q - SHW'(1);
        end else begin
          dout_d  = acc_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, latency, busy
// length, single-cycle done, ignored starts, back-to-back and async reset.
module tb_shift_sequencer;

  localparam int unsigned N   = 8;
  localparam int unsigned SHW = 3;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [1:0]     op;
  logic [N-1:0]   din;
  logic [SHW-1:0] shamt;
  logic           busy;
  logic           done;
  logic [N-1:0]   dout;

  int tests_run = 0;
  int tests_failed = 0;

  shift_sequencer #(.N(N), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .din   (din),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents the request, passes the acceptance edge E0,
  // and returns at the negedge right after E0.
  task automatic issue(input logic [1:0] o, input logic [7:0] d, input logic [2:0] s);
    start = 1'b1;
    op    = o;
    din   = d;
    shamt = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts at the negedge after E0; returns at the negedge where done is high.
  task automatic await_result(input string tag, input int k, input logic [7:0] exp,
                              input logic [7:0] prev, input bit disturb);
    int cycles   = 0;
    int busy_cnt = 0;
    bit held     = 1'b1;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (dout !== prev) held = 1'b0;
      if (disturb && cycles == 1) begin
        start = 1'b1;
        op    = 2'b01;
        din   = 8'h00;
        shamt = 3'd0;
      end else if (disturb && cycles == 2) begin
        start = 1'b0;
        op    = 2'b11;
        din   = 8'hFF;
        shamt = 3'd7;
      end
      cycles++;
      @(negedge clk);
    end
    check({tag, "_latency"}, cycles, k + 1);
    check({tag, "_busy_cycles"}, busy_cnt, k + 1);
    check({tag, "_dout_held"}, 32'(held), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'(exp));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic single(input string tag, input logic [1:0] o, input logic [7:0] d,
                        input logic [2:0] s, input logic [7:0] exp, input logic [7:0] prev);
    issue(o, d, s);
    await_result(tag, int'(s), exp, prev, 1'b0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_dout_after"}, 32'(dout), 32'(exp));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    din   = '0;
    shamt = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    single("srl_b4_3", 2'b00, 8'hB4, 3'd3, 8'h16, 8'h00);
    single("sll_b4_2", 2'b01, 8'hB4, 3'd2, 8'hD0, 8'h16);
    single("sra_90_3", 2'b10, 8'h90, 3'd3, 8'hF2, 8'hD0);
    single("ror_81_1", 2'b11, 8'h81, 3'd1, 8'hC0, 8'hF2);
    single("srl_ff_7", 2'b00, 8'hFF, 3'd7, 8'h01, 8'hC0);
    single("sra_5a_0", 2'b10, 8'h5A, 3'd0, 8'h5A, 8'h01);
    single("ror_b4_3", 2'b11, 8'hB4, 3'd3, 8'h96, 8'h5A);

    // Start pulsed and inputs changed mid-shift must be ignored.
    issue(2'b00, 8'hB4, 3'd3);
    await_result("ignored", 3, 8'h16, 8'h96, 1'b1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("ignored_no_extra_activity", seen, 0);
    check("ignored_dout_final", 32'(dout), 32'h16);

    // Back-to-back: new request presented during the done cycle.
    issue(2'b10, 8'h90, 3'd3);
    await_result("b2b_first", 3, 8'hF2, 8'h16, 1'b0);
    issue(2'b01, 8'h01, 3'd4);
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_second_done_low", 32'(done), 32'd0);
    await_result("b2b_second", 4, 8'h10, 8'hF2, 1'b0);
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(done), 32'd0);

    // Asynchronous reset mid-shift.
    issue(2'b00, 8'hFF, 3'd7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("async_rst_no_done", seen, 0);
    check("async_rst_dout_kept", 32'(dout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
